// File: rtl/upb_serial.sv
// G.726 UPB zero-section coefficient update, one tap per cycle across B1..B6.
// Optional UPB_STALL_EN: taps advance only on Un_valid; otherwise Un is taken every update cycle.
module upb_serial #(
   parameter int NTAPS = 6,
   parameter int BW    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            rate,
   input  logic [15:0]           DQ,
   input  logic                  tr,
   input  logic                  Un,
   input  logic                  Un_valid,
   output logic [2:0]            tap_sel,
   output logic                  busy,
   output logic                  done,
   output logic [NTAPS*BW-1:0]   bn_flat
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_UPD  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0]           LAST_TAP = 3'(NTAPS - 1);
   localparam logic signed [BW-1:0] STEP     = BW'(128);

   logic [1:0]            state;
   logic                  dq_nz;
   logic                  tr_c;
   logic [1:0]            rate_c;
   logic signed [BW-1:0]  bn [NTAPS];
   logic                  accept;
   logic signed [BW-1:0]  bn_cur;
   logic signed [BW-1:0]  bn_next;

   // Gradient step: +/- 2^-7 in Q14, suppressed when the captured DQ magnitude is zero.
   function automatic logic signed [BW-1:0] gain_step(input logic nz, input logic u);
      if (!nz)
         return '0;
      return u ? -STEP : STEP;
   endfunction

   // Leakage toward zero: 2^-9 at 40 kbit/s, 2^-8 at the other rates.
   function automatic logic signed [BW-1:0] leak_term(input logic signed [BW-1:0] b,
                                                      input logic [1:0] r);
      return (r == 2'b00) ? (b >>> 9) : (b >>> 8);
   endfunction

   function automatic logic signed [BW-1:0] next_coef(input logic signed [BW-1:0] b,
                                                      input logic nz, input logic u,
                                                      input logic [1:0] r, input logic t);
      if (t)
         return '0;
      return b + gain_step(nz, u) - leak_term(b, r);
   endfunction

`ifdef UPB_STALL_EN
   assign accept = (state == S_UPD) && Un_valid;
`else
   logic unused_un_valid;
   assign unused_un_valid = Un_valid;
   assign accept = (state == S_UPD);
`endif

   assign bn_cur  = bn[tap_sel];
   assign bn_next = next_coef(bn_cur, dq_nz, Un, rate_c, tr_c);

   // Per-sample operands are latched only when a start is accepted.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         dq_nz  <= |DQ[14:0];
         tr_c   <= tr;
         rate_c <= rate;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         tap_sel <= 3'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < NTAPS; i++)
            bn[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_UPD;
                  busy    <= 1'b1;
                  tap_sel <= 3'd0;
               end
            end
            S_UPD: begin
               if (accept) begin
                  bn[tap_sel] <= bn_next;
                  if (tap_sel == LAST_TAP) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     tap_sel <= 3'd0;
                  end else begin
                     tap_sel <= tap_sel + 3'd1;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_flat
      assign bn_flat[g*BW +: BW] = bn[g];
   end

endmodule
